// File: rtl/ad_usb_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_usb_packer: packs AD7606 samples into ping-pong USB packets w/ header  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ad_usb_packer #(
  parameter int                   DATA_NBIT = 16,
  parameter int                   ADDR_NBIT = 8,
  parameter int                   PKT_WORDS = 256,
  parameter logic [DATA_NBIT-1:0] SYNC_WORD = 16'hEB90
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DATA_NBIT-1:0] ad_data,
  input  logic                 ad_vd,
  output logic                 tx_cache_sop,
  input  logic [ADDR_NBIT-1:0] tx_cache_addr,
  output logic [DATA_NBIT-1:0] tx_cache_data,
  input  logic                 tx_cache_done,
  input  logic                 ovr_clr,
  output logic                 overrun,
  output logic [15:0]          drop_cnt
);

  localparam logic [1:0] c_FREE    = 2'd0;
  localparam logic [1:0] c_FILLING = 2'd1;
  localparam logic [1:0] c_READY   = 2'd2;
  localparam logic [1:0] c_READING = 2'd3;

  localparam logic [0:0] c_RD_IDLE = 1'b0;
  localparam logic [0:0] c_RD_BUSY = 1'b1;

  localparam logic [ADDR_NBIT-1:0] c_PTR_FIRST = ADDR_NBIT'(2);
  localparam logic [ADDR_NBIT-1:0] c_PTR_LAST  = ADDR_NBIT'(PKT_WORDS - 1);

  logic [DATA_NBIT-1:0] r_mem [2][PKT_WORDS];
  logic [1:0]           r_bank_st [2];
  logic [15:0]          r_bank_seq [2];
  logic                 r_wr_bank;
  logic [ADDR_NBIT-1:0] r_wr_ptr;
  logic [15:0]          r_seq;
  logic [0:0]           r_rd_st;
  logic                 r_rd_bank;
  logic                 r_sop;
  logic [DATA_NBIT-1:0] r_tx_data;
  logic                 r_ovr;
  logic [15:0]          r_drop_cnt;

  logic       w_vd;
  logic       w_wr_ok;
  logic       w_wr_en;
  logic       w_wr_last;
  logic       w_drop;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_any_ready;
  logic       w_pick;
  logic [0:0] w_rd_st_nxt;
  logic       w_rd_start;
  logic       w_rd_release;

  assign w_vd      = ad_vd & enable;
  assign w_wr_ok   = (r_bank_st[r_wr_bank] == c_FREE) || (r_bank_st[r_wr_bank] == c_FILLING);
  assign w_wr_en   = w_vd & w_wr_ok;
  assign w_drop    = w_vd & ~w_wr_ok;
  assign w_wr_last = w_wr_en && (r_wr_ptr == c_PTR_LAST);

  // With both banks READY the write side is stalled on the older one, so
  // r_wr_bank always names the bank that completed first.
  assign w_rdy0      = (r_bank_st[0] == c_READY);
  assign w_rdy1      = (r_bank_st[1] == c_READY);
  assign w_any_ready = w_rdy0 | w_rdy1;
  assign w_pick      = (w_rdy0 & w_rdy1) ? r_wr_bank : w_rdy1;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][r_wr_ptr] <= ad_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= c_PTR_FIRST;
      r_seq     <= 16'd0;
    end else if (w_wr_en) begin
      if (w_wr_last) begin
        r_wr_ptr  <= c_PTR_FIRST;
        r_wr_bank <= ~r_wr_bank;
        r_seq     <= r_seq + 16'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr + ADDR_NBIT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        r_bank_st[b]  <= c_FREE;
        r_bank_seq[b] <= 16'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_en && (r_wr_bank == 1'(b))) begin
          if (w_wr_last) begin
            r_bank_st[b]  <= c_READY;
            r_bank_seq[b] <= r_seq;
          end else begin
            r_bank_st[b] <= c_FILLING;
          end
        end else if (w_rd_start && (w_pick == 1'(b))) begin
          r_bank_st[b] <= c_READING;
        end else if (w_rd_release && (r_rd_bank == 1'(b))) begin
          r_bank_st[b] <= c_FREE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_st   <= c_RD_IDLE;
      r_rd_bank <= 1'b0;
      r_sop     <= 1'b0;
    end else begin
      r_rd_st <= w_rd_st_nxt;
      r_sop   <= w_rd_start;
      if (w_rd_start) begin
        r_rd_bank <= w_pick;
      end
    end
  end

  always_comb begin
    w_rd_st_nxt = r_rd_st;
    case (r_rd_st)
      c_RD_IDLE: if (w_any_ready)   w_rd_st_nxt = c_RD_BUSY;
      c_RD_BUSY: if (tx_cache_done) w_rd_st_nxt = c_RD_IDLE;
      default:                      w_rd_st_nxt = c_RD_IDLE;
    endcase
  end

  always_comb begin
    w_rd_start   = 1'b0;
    w_rd_release = 1'b0;
    case (r_rd_st)
      c_RD_IDLE: w_rd_start   = w_any_ready;
      c_RD_BUSY: w_rd_release = tx_cache_done;
      default: ;
    endcase
  end

  // Header words are muxed in rather than stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
    end else if (tx_cache_addr == ADDR_NBIT'(0)) begin
      r_tx_data <= SYNC_WORD;
    end else if (tx_cache_addr == ADDR_NBIT'(1)) begin
      r_tx_data <= DATA_NBIT'(r_bank_seq[r_rd_bank]);
    end else begin
      r_tx_data <= r_mem[r_rd_bank][tx_cache_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr      <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (ovr_clr) begin
      r_ovr      <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign tx_cache_sop  = r_sop;
  assign tx_cache_data = r_tx_data;
  assign overrun       = r_ovr;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ad_usb_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ad_usb_packer: directed scoreboard bench for ad_usb_packer              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ad_usb_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] ad_data = 16'd0;
  logic        ad_vd = 1'b0;
  logic        tx_cache_sop;
  logic [7:0]  tx_cache_addr = 8'd0;
  logic [15:0] tx_cache_data;
  logic        tx_cache_done = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        overrun;
  logic [15:0] drop_cnt;

  int          total = 0;
  int          bad = 0;
  logic        rd_issue = 1'b0;
  logic        pend = 1'b0;
  logic [23:0] expq [$];

  ad_usb_packer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .ad_data       (ad_data),
    .ad_vd         (ad_vd),
    .tx_cache_sop  (tx_cache_sop),
    .tx_cache_addr (tx_cache_addr),
    .tx_cache_data (tx_cache_data),
    .tx_cache_done (tx_cache_done),
    .ovr_clr       (ovr_clr),
    .overrun       (overrun),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Read data is registered, so compare one negedge after the address cycle.
  always @(negedge clk) begin
    if (pend) begin
      if (expq.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL rd_unexpected: got %h want <none>", tx_cache_data);
      end else begin
        logic [23:0] e;
        e = expq.pop_front();
        total = total + 1;
        if (tx_cache_data !== e[15:0]) begin
          bad = bad + 1;
          $display("FAIL rd_word[%0d]: got %h want %h", e[23:16], tx_cache_data, e[15:0]);
        end
      end
    end
    pend <= rd_issue;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      tick();
      ad_vd   = 1'b1;
      ad_data = base + 16'(i);
    end
    tick();
    ad_vd = 1'b0;
  endtask

  task automatic expect_sop(input string name);
    @(negedge clk); check({name, "_sop_early"}, 32'(tx_cache_sop), 32'd0);
    @(negedge clk); check({name, "_sop"},       32'(tx_cache_sop), 32'd1);
    @(negedge clk); check({name, "_sop_width"}, 32'(tx_cache_sop), 32'd0);
  endtask

  task automatic read_packet(input logic [15:0] seq, input logic [15:0] base);
    logic [15:0] w;
    for (int a = 0; a < 256; a++) begin
      tick();
      tx_cache_addr = 8'(a);
      rd_issue      = 1'b1;
      if (a == 0)      w = 16'hEB90;
      else if (a == 1) w = seq;
      else             w = base + 16'(a - 2);
      expq.push_back({8'(a), w});
    end
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic pulse_done();
    tick();
    tx_cache_done = 1'b1;
    tick();
    tx_cache_done = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sop",     32'(tx_cache_sop),  32'd0);
    check("rst_data",    32'(tx_cache_data), 32'd0);
    check("rst_overrun", 32'(overrun),       32'd0);
    check("rst_drop",    32'(drop_cnt),      32'd0);
    rst    = 1'b0;
    enable = 1'b1;

    // First packet: bank 0, seq 0
    burst(254, 16'h0000);
    expect_sop("p0");
    check("p0_rd_bank", 32'(dut.r_rd_bank), 32'd0);
    read_packet(16'h0000, 16'h0000);
    pulse_done();

    // Second packet: bank 1, seq 1
    burst(254, 16'h1000);
    expect_sop("p1");
    check("p1_rd_bank", 32'(dut.r_rd_bank), 32'd1);
    read_packet(16'h0001, 16'h1000);
    pulse_done();
    @(negedge clk);
    check("p1_overrun", 32'(overrun), 32'd0);

    // No done: fill both banks and drop 3 samples
    burst(511, 16'h2000);
    @(negedge clk);
    check("ovf_bank0_st", 32'(dut.r_bank_st[0]), 32'd3);
    check("ovf_bank1_st", 32'(dut.r_bank_st[1]), 32'd2);
    check("ovf_overrun",  32'(overrun),  32'd1);
    check("ovf_drop",     32'(drop_cnt), 32'd3);
    check("ovf_rd_bank",  32'(dut.r_rd_bank), 32'd0);
    read_packet(16'h0002, 16'h2000);
    pulse_done();
    expect_sop("ovf_b1");
    burst(1, 16'h3000);
    @(negedge clk);
    check("refill_ptr", 32'(dut.r_wr_ptr), 32'd3);
    check("refill_st",  32'(dut.r_bank_st[0]), 32'd1);
    burst(253, 16'h3001);

    // Stalled again on bank 1: clear wins over a same-cycle drop
    tick();
    ad_vd   = 1'b1;
    ovr_clr = 1'b1;
    ad_data = 16'hBAD0;
    tick();
    ad_vd   = 1'b0;
    ovr_clr = 1'b0;
    @(negedge clk);
    check("clr_overrun", 32'(overrun),  32'd0);
    check("clr_drop",    32'(drop_cnt), 32'd0);
    burst(1, 16'hBAD1);
    @(negedge clk);
    check("drop1_overrun", 32'(overrun),  32'd1);
    check("drop1_cnt",     32'(drop_cnt), 32'd1);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    @(negedge clk);
    check("clr2_drop", 32'(drop_cnt), 32'd0);
    check("b1_rd_bank", 32'(dut.r_rd_bank), 32'd1);
    read_packet(16'h0003, 16'h20FE);
    pulse_done();
    expect_sop("b0_after");
    read_packet(16'h0004, 16'h3000);
    pulse_done();

    // Enable low mid-packet
    burst(100, 16'h4000);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ad_vd   = 1'b1;
      ad_data = 16'hDEAD;
    end
    tick();
    ad_vd  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("en_ptr",  32'(dut.r_wr_ptr), 32'd102);
    check("en_drop", 32'(drop_cnt), 32'd0);
    burst(154, 16'h4064);
    expect_sop("en_pkt");
    read_packet(16'h0005, 16'h4000);
    pulse_done();

    // Sequence wrap from FFFF
    @(negedge clk);
    force dut.r_seq = 16'hFFFF;
    @(negedge clk);
    release dut.r_seq;
    burst(254, 16'h6000);
    expect_sop("seq_ffff");
    read_packet(16'hFFFF, 16'h6000);
    pulse_done();
    burst(254, 16'h7000);
    expect_sop("seq_wrap");
    read_packet(16'h0000, 16'h7000);
    pulse_done();

    // Asynchronous reset mid-fill
    burst(10, 16'h8000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ptr",  32'(dut.r_wr_ptr), 32'd2);
    check("arst_data", 32'(tx_cache_data), 32'd0);
    check("arst_st",   32'(dut.r_bank_st[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
